stack_seq_controller: RTL
=========================

# stack_seq_controller

Program sequencer for the 4-bit stack CPU. It buffers a short nibble program loaded through a valid/ready port. On `start`, it pulses the CPU reset and drives the CPU's nibble input cycle by cycle. Each opcode is presented in the fetch cycle and its operand is held for exactly as many execute cycles as the CPU spends on that op. It sits between the host/test harness and the CPU's `inbits`/`rst` inputs.

## Interface
- `DEPTH`, 16, program buffer entries (nibbles); power of two
- `ADDR_W`, 4, log2(DEPTH)
- `clk`  in  1  rising-edge clock, shared with the CPU
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- `load_valid`  in  1  host offers `load_data`
- `load_data`  in  4  program nibble
- `load_ready`  out  1  high only in IDLE; a transfer occurs when valid & ready at a clock edge
- `start`  in  1  single-cycle request to run the loaded program
- `cpu_rst`  out  1  drives the CPU reset (active high)
- `cpu_nibble`  out  4  drives the CPU `inbits`
- `busy`  out  1  high from the accepted `start` until DONE
- `done`  out  1  one-cycle pulse when the program ends
- `pc`  out  ADDR_W  buffer index of the current opcode

## Operation
- Program format: opcode nibble, optionally followed by one operand nibble.
  - Operand-carrying opcodes: 0x1 PUSH (data), 0x6 PUSF, 0x7 REPL, 0x8 BIN (selector).
  - 0xF is HALT. The CPU sees it as a NOOP; the sequencer ends on it.
- Execute-cycle count per opcode: 0x1, 0x2, 0x5, 0x6, 0x7, 0x8 = 2; 0x9 = 3; all others = 1.
- Load path: each accepted nibble is written at `wr_ptr`, then `wr_ptr` increments.
  - `wr_ptr` wraps modulo DEPTH; a wrap overwrites the oldest entries.
  - `wr_ptr` clears only on reset.
- States:
  - IDLE: `load_ready`=1. `start` moves to CRST; `pc`←0.
  - CRST: `cpu_rst`=1 for one cycle, then FETCH.
  - FETCH: `cpu_nibble`=mem[pc]; latch the opcode and its cycle count.
    - If the opcode is HALT, or pc==`wr_ptr` (buffer empty or exhausted), go to DONE.
    - Otherwise go to EXEC.
  - EXEC: `cpu_nibble`=operand (mem[pc+1]) if the opcode carries one, else 0.
    - A cycle counter counts down; on the last cycle, pc advances by 1 or 2 (modulo DEPTH), then FETCH.
  - DONE: `done`=1, `busy`=0, then IDLE.
- A missing operand (operand slot == `wr_ptr`) is driven as 0 and the program ends after that op.
- `start` while not IDLE is ignored.
- `start` and `load_valid` in the same IDLE cycle: the load is taken and `start` is ignored.
- Reset mid-run: immediate return to IDLE. The buffer contents are kept; `wr_ptr` is cleared.

## Timing
- All outputs are registered, except `load_ready`, which is a state decode.
- Reset values: `cpu_rst`=1, `cpu_nibble`=0, `busy`=0, `done`=0, `pc`=0, `load_ready`=0 while `rst_n` is low.
  - The first edge after release goes to IDLE with `cpu_rst`=0. This gives the CPU one reset edge.
- A FETCH cycle is followed by EXEC cycles in back-to-back clocks, with no bubbles.
- Run length = 1 (CRST) + Σ(1 + exec_cycles) + 1 (terminating FETCH). DONE is the next cycle.
- `busy` rises the cycle after `start` is accepted.
- `done` is asserted in the same cycle `busy` falls.

## Structure
- Package `stack_seq_pkg`:
  - opcode constants OP_PUSH..OP_MUL and OP_HALT
  - the state enum
  - operand-carrying predicate and cycle-count constants
- Sub-module `op_length_decoder`: combinational opcode → {exec_cycles[1:0], has_operand}. It is reused by verification.
- Program memory is a flop array of DEPTH × 4.

## Test plan
- Load 1,5,1,3,8,0,3,F, then start.
  - Required: CPU output after `done` is 0x08.
  - Required: `done` exactly 14 cycles after `start` is accepted (CRST 1, three 3-cycle ops, OUTL 2, HALT fetch 1, DONE at 14).
- Load 1,3,1,4,9,3,F.
  - Required: MUL is given 3 EXEC cycles with `cpu_nibble`=0.
  - Required: OUTL shows low nibble 0xC.
- Start with an empty buffer.
  - Required: CRST, FETCH, DONE; `done` on cycle 3; no CPU op issued.
- Program ending in 1 with no operand.
  - Required: operand driven as 0; `done` follows PUSH.
- During a run, assert `load_valid` and `start`.
  - Required: `load_ready`=0, nothing written, start ignored.
  - Then pull `rst_n` low mid-EXEC. Required: `cpu_rst`=1 at once, `busy`=0, `pc`=0.
- Load 17 nibbles with DEPTH=16.
  - Required: `wr_ptr`=1 and entry 0 holds the 17th nibble.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - opcodes, cycle counts and state encoding for the stack CPU sequencer
package stack_seq_pkg;

  // CPU opcode nibbles
  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_DUP  = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_REPL = 4'h7;
  localparam logic [3:0] OP_BIN  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Execute-cycle counts the CPU spends after the fetch cycle
  localparam logic [1:0] CYC_ONE   = 2'd1;
  localparam logic [1:0] CYC_TWO   = 2'd2;
  localparam logic [1:0] CYC_THREE = 2'd3;

  // ST_RST holds the CPU in reset while rst_n is low and for the first edge after release
  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_CRST,
    ST_FETCH,
    ST_EXEC,
    ST_DONE
  } seq_state_t;

  // Opcodes whose next program nibble is an operand rather than an opcode
  function automatic logic op_has_operand(input logic [3:0] op);
    return (op == OP_PUSH) || (op == OP_PUSF) || (op == OP_REPL) || (op == OP_BIN);
  endfunction

endpackage

// File: rtl/op_length_decoder.sv
// rtl/op_length_decoder.sv - opcode to execute-cycle count and operand flag
import stack_seq_pkg::*;

module op_length_decoder (
  input  logic [3:0] op,
  output logic [1:0] exec_cycles,
  output logic       has_operand
);

  // Pure table lookup; HALT is a one-cycle NOOP as far as the CPU is concerned
  always_comb begin
    exec_cycles = CYC_ONE;
    has_operand = op_has_operand(op);
    case (op)
      OP_PUSH, OP_POP, OP_SWAP, OP_PUSF, OP_REPL, OP_BIN: exec_cycles = CYC_TWO;
      OP_MUL:                                             exec_cycles = CYC_THREE;
      OP_NOOP, OP_OUTL, OP_DUP, OP_HALT:                  exec_cycles = CYC_ONE;
      default:                                            exec_cycles = CYC_ONE;
    endcase
  end

endmodule

// File: rtl/stack_seq_controller.sv
// rtl/stack_seq_controller.sv - buffers a nibble program and replays it into the stack CPU
import stack_seq_pkg::*;

module stack_seq_controller #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [3:0]        load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              cpu_rst,
  output logic [3:0]        cpu_nibble,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  logic [3:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  seq_state_t        state, state_nxt;
  logic [1:0]        cnt_q, cnt_nxt;
  logic              two_q, two_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              cpu_rst_nxt;
  logic [3:0]        nib_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic              load_fire;
  logic [3:0]        fetch_op;
  logic [1:0]        exec_cycles;
  logic              has_operand;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_step;
  logic              opnd_present;

  assign load_ready = (state == ST_IDLE);
  assign load_fire  = load_valid && load_ready;
  assign fetch_op   = mem[pc];
  assign pc_plus1   = pc + ADDR_W'(1);
  // A missing operand advances pc by one only, landing on wr_ptr so the next fetch ends the run
  assign pc_step      = pc + (two_q ? ADDR_W'(2) : ADDR_W'(1));
  assign opnd_present = has_operand && (pc_plus1 != wr_ptr);

  op_length_decoder u_len (
    .op          (fetch_op),
    .exec_cycles (exec_cycles),
    .has_operand (has_operand)
  );

  // Program buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= load_data;
    end
  end

  // Write pointer wraps modulo DEPTH and clears only on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (load_fire) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

  // Next-state and next-output decode; outputs are registered so each value matches the state entered
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    cnt_nxt     = cnt_q;
    two_nxt     = two_q;
    cpu_rst_nxt = 1'b0;
    nib_nxt     = 4'h0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      ST_RST: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      ST_IDLE: begin
        busy_nxt = 1'b0;
        // A load in the same cycle takes priority over start
        if (start && !load_valid) begin
          state_nxt   = ST_CRST;
          pc_nxt      = '0;
          cpu_rst_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      ST_CRST: begin
        state_nxt = ST_FETCH;
        // An empty slot is shown as 0 so the CPU never sees a stale nibble
        nib_nxt   = (pc == wr_ptr) ? 4'h0 : mem[pc];
      end
      ST_FETCH: begin
        if ((pc == wr_ptr) || (fetch_op == OP_HALT)) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = ST_EXEC;
          cnt_nxt   = exec_cycles - 2'd1;
          two_nxt   = opnd_present;
          nib_nxt   = opnd_present ? mem[pc_plus1] : 4'h0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 2'd0) begin
          state_nxt = ST_FETCH;
          pc_nxt    = pc_step;
          nib_nxt   = (pc_step == wr_ptr) ? 4'h0 : mem[pc_step];
        end else begin
          cnt_nxt = cnt_q - 2'd1;
          nib_nxt = cpu_nibble;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt   = ST_RST;
        cpu_rst_nxt = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset holds the CPU in reset immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      pc         <= '0;
      cnt_q      <= 2'd0;
      two_q      <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_nibble <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      cnt_q      <= cnt_nxt;
      two_q      <= two_nxt;
      cpu_rst    <= cpu_rst_nxt;
      cpu_nibble <= nib_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule
